addr_seq_gen: RTL and testbench

Parametrised, handshaked address sequencer. On a start command it emits a burst of `count` addresses beginning at `base` and advancing by `stride` (modulo 2^ADDR_W). Each address is presented with valid/ready flow control, and a one-cycle done pulse follows the burst. It sits between a control FSM and a memory/register-file port, and generalises the fixed two-value address lookup used elsewhere in the design.

---
 rtl/addr_seq_gen.sv | 169 ++++++++++++++++
 tb/tb_addr_seq_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_seq_gen.sv
// addr_seq_gen
//
// Handshaked address sequencer. A start command in IDLE captures base, stride
// and count, then emits count addresses beginning at base and stepping by
// stride (modulo 2^ADDR_W) under valid/ready flow control. A one-cycle done
// pulse follows the last transfer, or follows the start directly for an
// empty burst (count == 0).
//
// Optional feature macro: ADDR_SEQ_GEN_DOWN_EN
//   When defined, adds input `dir` (captured with start). dir=1 descends
//   (addr - stride), dir=0 ascends. When undefined, sequencing is ascending.
//
// Ports:
//   clk     in   clock, all state on rising edge
//   rst     in   asynchronous active-high reset
//   start   in   burst request, sampled only in IDLE
//   base    in   first address, captured with start
//   stride  in   address increment, captured with start
//   count   in   number of addresses, captured with start
//   dir     in   (ADDR_SEQ_GEN_DOWN_EN only) 1 = descending
//   ready   in   consumer accepts addr when valid && ready
//   addr    out  current address (registered)
//   valid   out  addr is valid (registered)
//   busy    out  high in RUN and DONE
//   done    out  one-cycle pulse after the burst

module addr_seq_gen #(
    parameter int unsigned          ADDR_W     = 4,
    parameter int unsigned          CNT_W      = 4,
    parameter logic [ADDR_W-1:0]    RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    input  logic [CNT_W-1:0]  count,
`ifdef ADDR_SEQ_GEN_DOWN_EN
    input  logic              dir,
`endif
    input  logic              ready,
    output logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              dir_q, dir_d;
    logic              dir_in;
    logic [ADDR_W-1:0] next_addr;

`ifdef ADDR_SEQ_GEN_DOWN_EN
    assign dir_in = dir;
`else
    assign dir_in = 1'b0;
`endif

    // Carry/borrow is discarded so the sequence wraps modulo 2^ADDR_W.
    always_comb begin
        if (dir_q) begin
            next_addr = addr_q - stride_q;
        end else begin
            next_addr = addr_q + stride_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        stride_d    = stride_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;

        case (state_q)
            ST_IDLE: begin
                addr_d  = RESET_ADDR;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    stride_d = stride;
                    dir_d    = dir_in;
                    busy_d   = 1'b1;
                    if (count != '0) begin
                        state_d     = ST_RUN;
                        addr_d      = base;
                        valid_d     = 1'b1;
                        remaining_d = count;
                    end else begin
                        // Empty burst: straight to the done pulse, valid never rises.
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        remaining_d = '0;
                    end
                end
            end

            ST_RUN: begin
                // Without a transfer everything holds, so valid cannot drop.
                if (valid_q && ready) begin
                    if (remaining_q == CNT_W'(1)) begin
                        state_d     = ST_DONE;
                        valid_d     = 1'b0;
                        done_d      = 1'b1;
                        remaining_d = '0;
                    end else begin
                        addr_d      = next_addr;
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                addr_d  = RESET_ADDR;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                addr_d  = RESET_ADDR;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= RESET_ADDR;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stride_q    <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stride_q    <= stride_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
        end
    end

    assign addr  = addr_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_addr_seq_gen.sv
// Directed bench for addr_seq_gen. Expected addresses are queued when a burst
// is started and popped on every observed transfer (valid && ready at the
// falling edge, i.e. the transfer taken at the following rising edge).

module tb_addr_seq_gen;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CNT_W  = 4;
    localparam logic [ADDR_W-1:0] RST_ADDR = 4'd0;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] stride;
    logic [CNT_W-1:0]  count;
    logic              dir;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic              busy;
    logic              done;

    int errors;
    int checks;
    int xfers;
    int done_cnt;
    int valid_cycles;
    int cycles;
    logic [ADDR_W-1:0] exp_q[$];

    addr_seq_gen #(
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .RESET_ADDR(RST_ADDR)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .base  (base),
        .stride(stride),
        .count (count),
`ifdef ADDR_SEQ_GEN_DOWN_EN
        .dir   (dir),
`endif
        .ready (ready),
        .addr  (addr),
        .valid (valid),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge, then advance to just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (valid && ready) begin
            xfers++;
            check("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("xfer_addr", 32'(addr), 32'(exp_q.pop_front()));
        end
        if (valid) valid_cycles++;
        if (done) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                              input int n, input logic down);
        logic [ADDR_W-1:0] a;
        a = b;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a);
            a = down ? a - s : a + s;
        end
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                            input logic [CNT_W-1:0] n, input logic down);
        push_burst(b, s, int'(n), down);
        base   = b;
        stride = s;
        count  = n;
        dir    = down;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        base   = 4'hf;
        stride = 4'hf;
        count  = 4'hf;
    endtask

    // Ticks until done is visible; cycles counts ticks after the start edge.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("done_valid_low", 32'(valid), 32'd0);
        check("done_busy_high", 32'(busy), 32'd1);
    endtask

    task automatic clear_counts();
        xfers        = 0;
        done_cnt     = 0;
        valid_cycles = 0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clear_counts();
        rst    = 1'b1;
        start  = 1'b0;
        base   = '0;
        stride = '0;
        count  = '0;
        dir    = 1'b0;
        ready  = 1'b1;
        #1;
        check("rst_addr", 32'(addr), 32'(RST_ADDR));
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        tick();
        check("idle_addr", 32'(addr), 32'(RST_ADDR));

        // Basic burst 3,5,7,9.
        clear_counts();
        do_start(4'd3, 4'd2, 4'd4, 1'b0);
        check("basic_first_valid", 32'(valid), 32'd1);
        check("basic_first_addr", 32'(addr), 32'd3);
        check("basic_busy", 32'(busy), 32'd1);
        wait_done(cycles);
        check("basic_cycles", 32'(cycles), 32'd4);
        tick();
        check("basic_idle_busy", 32'(busy), 32'd0);
        check("basic_idle_done", 32'(done), 32'd0);
        check("basic_idle_addr", 32'(addr), 32'(RST_ADDR));
        check("basic_xfers", 32'(xfers), 32'd4);
        check("basic_done_cnt", 32'(done_cnt), 32'd1);
        check("basic_q_empty", 32'(exp_q.size()), 32'd0);

        // Wrap-around 14,1,4 with back-to-back start at the first IDLE edge.
        clear_counts();
        do_start(4'd14, 4'd3, 4'd3, 1'b0);
        wait_done(cycles);
        check("wrap_cycles", 32'(cycles), 32'd3);
        tick();
        check("wrap_xfers", 32'(xfers), 32'd3);
        check("wrap_done_cnt", 32'(done_cnt), 32'd1);
        check("wrap_q_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: stall two cycles on addr=1.
        clear_counts();
        do_start(4'd0, 4'd1, 4'd3, 1'b0);
        tick();
        check("bp_addr1", 32'(addr), 32'd1);
        ready = 1'b0;
        tick();
        check("bp_hold1_addr", 32'(addr), 32'd1);
        check("bp_hold1_valid", 32'(valid), 32'd1);
        tick();
        check("bp_hold2_addr", 32'(addr), 32'd1);
        check("bp_hold2_valid", 32'(valid), 32'd1);
        ready = 1'b1;
        wait_done(cycles);
        tick();
        check("bp_xfers", 32'(xfers), 32'd3);
        check("bp_valid_cycles", 32'(valid_cycles), 32'd5);
        check("bp_done_cnt", 32'(done_cnt), 32'd1);
        check("bp_q_empty", 32'(exp_q.size()), 32'd0);

        // Empty burst: done in the cycle after start, valid never high.
        clear_counts();
        do_start(4'd7, 4'd1, 4'd0, 1'b0);
        check("empty_done", 32'(done), 32'd1);
        check("empty_busy", 32'(busy), 32'd1);
        check("empty_valid", 32'(valid), 32'd0);
        tick();
        check("empty_idle_busy", 32'(busy), 32'd0);
        tick();
        check("empty_valid_cycles", 32'(valid_cycles), 32'd0);
        check("empty_done_cnt", 32'(done_cnt), 32'd1);

        // Start pulsed mid-RUN with different parameters is ignored.
        clear_counts();
        do_start(4'd0, 4'd4, 4'd4, 1'b0);
        tick();
        start  = 1'b1;
        base   = 4'd9;
        stride = 4'd5;
        count  = 4'd2;
        tick();
        start  = 1'b0;
        wait_done(cycles);
        tick();
        tick();
        check("ign_xfers", 32'(xfers), 32'd4);
        check("ign_done_cnt", 32'(done_cnt), 32'd1);
        check("ign_q_empty", 32'(exp_q.size()), 32'd0);
        check("ign_idle_busy", 32'(busy), 32'd0);

        // Reset mid-burst on the 2nd address.
        clear_counts();
        do_start(4'd1, 4'd1, 4'd5, 1'b0);
        tick();
        check("rstmid_addr2", 32'(addr), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_addr", 32'(addr), 32'(RST_ADDR));
        check("rstmid_valid", 32'(valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("rstmid_no_done", 32'(done_cnt), 32'd0);
        clear_counts();
        do_start(4'd5, 4'd2, 4'd2, 1'b0);
        wait_done(cycles);
        tick();
        check("post_rst_xfers", 32'(xfers), 32'd2);
        check("post_rst_done_cnt", 32'(done_cnt), 32'd1);
        check("post_rst_q_empty", 32'(exp_q.size()), 32'd0);

`ifdef ADDR_SEQ_GEN_DOWN_EN
        // Descending 2,1,0,15.
        clear_counts();
        do_start(4'd2, 4'd1, 4'd4, 1'b1);
        wait_done(cycles);
        tick();
        check("down_xfers", 32'(xfers), 32'd4);
        check("down_done_cnt", 32'(done_cnt), 32'd1);
        check("down_q_empty", 32'(exp_q.size()), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
